// File: rtl/rock_pkg.sv
// Shared constants and helpers for the cradle rocking scheduler.
// Level width, FSM state codes and default thresholds live here.
package rock_pkg;

  localparam int LVL_W = 3;

  typedef logic [LVL_W-1:0] lvl_t;

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] RAMP_UP   = 2'd1;
  localparam logic [1:0] HOLD      = 2'd2;
  localparam logic [1:0] RAMP_DOWN = 2'd3;

  localparam int         DEF_TICKS_PER_STEP = 4;
  localparam logic [7:0] DEF_CRY_ON         = 8'd100;
  localparam logic [7:0] DEF_CRY_OFF        = 8'd40;
  localparam logic [7:0] DEF_HR_HIGH        = 8'd140;
  localparam int         DEF_CALM_TICKS     = 16;
  localparam lvl_t       DEF_AMP_MAX        = 3'd7;
  localparam lvl_t       DEF_FREQ_NORM      = 3'd5;
  localparam lvl_t       DEF_FREQ_CALM      = 3'd3;

  function automatic lvl_t lvl_toward(input lvl_t cur, input lvl_t tgt);
    if (cur < tgt) return cur + lvl_t'(1);
    if (cur > tgt) return cur - lvl_t'(1);
    return cur;
  endfunction

endpackage

// File: rtl/rock_step_timer.sv
// Tick prescaler producing one step every TICKS ticks.
// Clear restarts the count; stall freezes it and masks the step.
module rock_step_timer #(
  parameter int TICKS = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  input  logic clear,
  input  logic stall,
  output logic step
);

  localparam int CW = (TICKS > 1) ? $clog2(TICKS) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICKS - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // step must not depend on clear: clear is derived from the next state
  assign step = tick && !stall && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clear)
      cnt_d = '0;
    else if (!stall && tick)
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/rock_sequencer.sv
// Closed-loop rocking scheduler: ramps cradle amplitude/frequency
// from latched cry/heart-rate samples and hands each setting off.
module rock_sequencer
  import rock_pkg::*;
#(
  parameter int         TICKS_PER_STEP = DEF_TICKS_PER_STEP,
  parameter logic [7:0] CRY_ON         = DEF_CRY_ON,
  parameter logic [7:0] CRY_OFF        = DEF_CRY_OFF,
  parameter logic [7:0] HR_HIGH        = DEF_HR_HIGH,
  parameter int         CALM_TICKS     = DEF_CALM_TICKS,
  parameter lvl_t       AMP_MAX        = DEF_AMP_MAX,
  parameter lvl_t       FREQ_NORM      = DEF_FREQ_NORM,
  parameter lvl_t       FREQ_CALM      = DEF_FREQ_CALM
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       enable,
  input  logic       sample_valid,
  input  logic [7:0] hartslag,
  input  logic [7:0] huilVol,
  output logic [2:0] amp,
  output logic [2:0] freq,
  output logic       cmd_valid,
  input  logic       cmd_ready,
  output logic [1:0] state
);

  localparam int CALM_W = $clog2(CALM_TICKS + 1);
  localparam logic [CALM_W-1:0] CALM_FULL = CALM_W'(CALM_TICKS);

  logic [7:0]        hr_q, hr_d, cry_q, cry_d;
  logic [1:0]        state_q, state_d;
  lvl_t              amp_q, amp_d, freq_q, freq_d;
  logic              cmd_valid_q, cmd_valid_d;
  logic [CALM_W-1:0] calm_q, calm_d;

  logic step, stall, loud, quiet, changed;
  lvl_t ft;

  assign stall = cmd_valid_q && !cmd_ready;
  assign loud  = cry_q >= CRY_ON;
  assign quiet = cry_q < CRY_OFF;
  assign ft    = (hr_q >= HR_HIGH) ? FREQ_CALM : FREQ_NORM;

  rock_step_timer #(.TICKS(TICKS_PER_STEP)) u_timer (
    .clk   (clk),
    .reset (reset),
    .tick  (tick && (state_q != IDLE)),
    .clear ((state_d != state_q) || (state_q == IDLE)),
    .stall (stall),
    .step  (step)
  );

  always_comb begin
    state_d = state_q;
    amp_d   = amp_q;
    freq_d  = freq_q;
    calm_d  = '0;
    unique case (state_q)
      IDLE: begin
        amp_d  = '0;
        freq_d = '0;
        if (enable && loud) state_d = RAMP_UP;
      end
      RAMP_UP: begin
        if (!enable) begin
          state_d = RAMP_DOWN;
        end else if (step) begin
          amp_d  = (amp_q < AMP_MAX) ? amp_q + lvl_t'(1) : amp_q;
          freq_d = lvl_toward(freq_q, ft);
          if (amp_d == AMP_MAX && freq_d == ft) state_d = HOLD;
        end
      end
      HOLD: begin
        if (!enable) begin
          state_d = RAMP_DOWN;
        end else begin
          if (step) freq_d = lvl_toward(freq_q, ft);
          if (calm_q == CALM_FULL)
            state_d = RAMP_DOWN;
          else if (tick)
            calm_d = quiet ? calm_q + CALM_W'(1) : '0;
          else
            calm_d = calm_q;
        end
      end
      RAMP_DOWN: begin
        if (enable && loud) begin
          state_d = RAMP_UP;
        end else begin
          if (step) begin
            amp_d  = (amp_q != '0) ? amp_q - lvl_t'(1) : amp_q;
            freq_d = (freq_q != '0) ? freq_q - lvl_t'(1) : freq_q;
          end
          if (amp_d == '0 && freq_d == '0) state_d = IDLE;
        end
      end
    endcase
  end

  assign changed     = (amp_d != amp_q) || (freq_d != freq_q);
  assign cmd_valid_d = changed || stall;
  assign hr_d        = sample_valid ? hartslag : hr_q;
  assign cry_d       = sample_valid ? huilVol : cry_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      amp_q       <= '0;
      freq_q      <= '0;
      cmd_valid_q <= 1'b0;
      calm_q      <= '0;
      hr_q        <= '0;
      cry_q       <= '0;
    end else begin
      state_q     <= state_d;
      amp_q       <= amp_d;
      freq_q      <= freq_d;
      cmd_valid_q <= cmd_valid_d;
      calm_q      <= calm_d;
      hr_q        <= hr_d;
      cry_q       <= cry_d;
    end
  end

  assign amp       = amp_q;
  assign freq      = freq_q;
  assign cmd_valid = cmd_valid_q;
  assign state     = state_q;

endmodule

// File: doc/rock_sequencer.md
Name: rock_sequencer

Overview:
Closed-loop rocking scheduler. Escalates and de-escalates the rocking amplitude and frequency of the cradle actuator from latched cry-volume and heart-rate samples. Settings move one level per step period, paced by the system tick. Every new setting is handed to the actuator driver over a valid/ready handshake. Sits between the sensor front-end (hartslag, huilVol) and the motor driver, replacing direct level control.

Parameters:
TICKS_PER_STEP, 4, tick pulses per ramp step (>=1)
CRY_ON, 8'd100, huilVol at or above this starts/re-escalates rocking
CRY_OFF, 8'd40, huilVol below this counts as calm
HR_HIGH, 8'd140, hartslag at or above this selects the calm frequency target
CALM_TICKS, 16, consecutive calm ticks in HOLD before ramp-down
AMP_MAX, 3'd7, amplitude target
FREQ_NORM, 3'd5, frequency target when hartslag < HR_HIGH
FREQ_CALM, 3'd3, frequency target when hartslag >= HR_HIGH

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low reset
tick  in  1  one-cycle timing pulse
enable  in  1  rocking permitted
sample_valid  in  1  hartslag/huilVol valid this cycle
hartslag  in  8  heart rate sample
huilVol  in  8  cry volume sample
amp  out  3  current amplitude setting
freq  out  3  current frequency setting
cmd_valid  out  1  new amp/freq pending for the actuator
cmd_ready  in  1  actuator accepts the pending command
state  out  2  FSM state (debug)

Behaviour:
- Reset (reset==0 at posedge clk): amp=0, freq=0, cmd_valid=0, state=IDLE, step/calm counters=0, latched hr_q/cry_q=0.
- Sample latch: sample_valid loads hr_q/cry_q on the next edge. Decisions use only the latched values, so a sample affects the FSM at the earliest one cycle after capture.
- Freq target ft = (hr_q >= HR_HIGH) ? FREQ_CALM : FREQ_NORM, re-evaluated every step.
- Step timer: counts ticks only in RAMP_UP, HOLD and RAMP_DOWN. step = tick && cnt==TICKS_PER_STEP-1, after which cnt wraps to 0. cnt clears on every state change. It holds without wrapping (step suppressed, tick ignored) while cmd_valid && !cmd_ready.
- IDLE: amp=freq=0. Moves to RAMP_UP when enable && cry_q >= CRY_ON.
- RAMP_UP: on step, amp+1 if amp<AMP_MAX. freq moves one toward ft (up or down). When amp==AMP_MAX and freq==ft after an update, moves to HOLD.
- HOLD: on each tick, calm_cnt+1 if cry_q < CRY_OFF, else calm_cnt=0. calm_cnt saturates at CALM_TICKS. freq still tracks ft by one level per step. When calm_cnt==CALM_TICKS, moves to RAMP_DOWN and clears calm_cnt.
- RAMP_DOWN: on step, amp-1 and freq-1, each saturating at 0. Goes back to RAMP_UP if enable && cry_q >= CRY_ON. Goes to IDLE when amp==0 and freq==0.
- enable==0 in RAMP_UP or HOLD forces RAMP_DOWN on the next edge. In IDLE, enable==0 blocks escalation.
- Handshake: any cycle in which amp or freq changes sets cmd_valid=1 on that same edge. cmd_valid stays at 1 until a cycle with cmd_valid && cmd_ready, then clears, unless another change occurs on that same edge.
- No amp/freq change while cmd_valid && !cmd_ready. amp/freq stay stable while cmd_valid is high.
- Priority within a cycle: reset > enable-drop > re-escalation (RAMP_DOWN) > step update > calm counting.
- A simultaneous sample_valid and step uses the old latched values.
- Reset mid-ramp returns everything to the reset values on that edge. No command is issued for the drop to 0.
- Widths: amp/freq are 3-bit unsigned and never wrap. calm_cnt is $clog2(CALM_TICKS+1) bits. Step counter is $clog2(TICKS_PER_STEP) bits, minimum 1.

Decomposition:
- Package rock_pkg holds:
  - state enum: IDLE=0, RAMP_UP=1, HOLD=2, RAMP_DOWN=3
  - LVL_W=3
  - default threshold constants
- One sub-module, rock_step_timer: tick prescaler with clear and stall inputs and a step output.

Test Plan:
- Escalation: enable=1, cmd_ready=1, sample huilVol=120, hartslag=100, then 4-tick spacing -> amp/freq step every 4 ticks. After 5 steps: amp=5, freq=5. After 7 steps: amp=7, freq=5, then HOLD. Exactly 7 single-cycle cmd_valid pulses.
- HR retarget: in HOLD with freq=5, sample hartslag=150 -> freq goes 4 then 3 on the next two steps. amp stays 7 and state stays HOLD.
- Calm-down: in HOLD, huilVol=20 -> RAMP_DOWN after 16 ticks. A calm sample interrupted by huilVol=60 at tick 10 restarts the count, so RAMP_DOWN comes 16 ticks after the last loud tick. Levels then fall to 0/0 and the FSM returns to IDLE.
- Re-escalation: in RAMP_DOWN at amp=4, sample huilVol=110 -> RAMP_UP next cycle, counter cleared, amp=5 after 4 ticks.
- Backpressure: cmd_ready=0 for 20 ticks during RAMP_UP -> amp/freq frozen and cmd_valid held high. cmd_ready=1 -> accepted, and the next step occurs 4 ticks later.
- Reset/enable: drop enable in HOLD -> RAMP_DOWN next edge. Assert reset=0 mid-ramp -> amp=0, freq=0, cmd_valid=0, state=IDLE on that edge.
